// File: rtl/pmod_maxsonar_ranger.sv
// pmod_maxsonar_ranger: multi-channel MaxSonar PW capture, converted to whole inches
// Ports:
//   aclk, aresetn       clock, async active-low reset
//   gpio_tri_i/o/t      Pmod top-row GPIO; ch n: PW in on bit 4n+3, RX out on bit 4n+0
//   trig_i              per-channel one-cycle range request (triggered mode only)
//   range_o             last range per channel, RANGE_W bits each, saturating
//   range_valid_o       one-cycle strobe on range_o update
//   timeout_o           sticky timeout flag, cleared by the next valid result
//   busy_o              channel FSM not in IDLE
module pmod_maxsonar_ranger #(
  parameter int NUM_CH          = 1,
  parameter int CYCLES_PER_INCH = 14700,
  parameter int RANGE_W         = 9,
  parameter int TRIG_MODE       = 0,
  parameter int TRIG_CYCLES     = 2500,
  parameter int TIMEOUT_CYCLES  = 10000000
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [4*NUM_CH-1:0]       gpio_tri_i,
  output logic [4*NUM_CH-1:0]       gpio_tri_o,
  output logic [4*NUM_CH-1:0]       gpio_tri_t,
  input  logic [NUM_CH-1:0]         trig_i,
  output logic [NUM_CH*RANGE_W-1:0] range_o,
  output logic [NUM_CH-1:0]         range_valid_o,
  output logic [NUM_CH-1:0]         timeout_o,
  output logic [NUM_CH-1:0]         busy_o
);
  localparam int PS_W = $clog2(CYCLES_PER_INCH);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam int TG_W = $clog2(TRIG_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, TRIG, ARMED, HIGH, WAIT_LOW} state_t;
  // where a channel goes after a measurement or an abandoned wait
  localparam state_t DONE = (TRIG_MODE != 0) ? IDLE : ARMED;
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    state_t state, state_nxt;
    logic s1, s2, prev, out_en;
    logic rise, fall, wrap, to_hit, to_evt, capture, rx, busy;
    logic valid, tmo;
    logic [RANGE_W-1:0] rng, inch, inch_nxt;
    logic [PS_W-1:0] presc;
    logic [TO_W-1:0] to_cnt;
    logic [TG_W-1:0] tg_cnt;
    logic unused_in;
    assign unused_in = ^gpio_tri_i[4*n +: 3];
    // 2-FF synchroniser plus one register for edge detection; out_en releases the RX driver
    always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) {prev, s2, s1, out_en} <= '0;
      else {prev, s2, s1, out_en} <= {s2, s1, gpio_tri_i[4*n+3], 1'b1};
    assign rise     = s2 & ~prev;
    assign fall     = ~s2 & prev;
    assign wrap     = presc == PS_W'(CYCLES_PER_INCH - 1);
    assign inch_nxt = (wrap && inch != '1) ? inch + 1'b1 : inch;
    assign to_hit   = to_cnt > TO_W'(TIMEOUT_CYCLES);
    always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) state <= IDLE;
      else state <= state_nxt;
    // edges take priority over timeouts
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:     if (TRIG_MODE == 0) state_nxt = ARMED; else if (trig_i[n]) state_nxt = TRIG;
        TRIG:     if (tg_cnt == '0) state_nxt = ARMED;
        ARMED:    if (rise) state_nxt = HIGH; else if (to_hit) state_nxt = DONE;
        HIGH:     if (fall) state_nxt = DONE; else if (to_hit) state_nxt = WAIT_LOW;
        WAIT_LOW: if (fall) state_nxt = DONE;
        default:  state_nxt = IDLE;
      endcase
    end
    always_comb begin
      rx      = (TRIG_MODE != 0) ? (state == TRIG) : out_en;
      busy    = state != IDLE;
      capture = (state == HIGH) && fall;
      to_evt  = to_hit && ((state == ARMED && !rise) || (state == HIGH && !fall));
    end
    // timeout counter restarts on every state change and on each expiry
    always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
        valid  <= 1'b0;
        tmo    <= 1'b0;
        rng    <= '0;
        inch   <= '0;
        presc  <= '0;
        to_cnt <= '0;
        tg_cnt <= '0;
      end else begin
        valid  <= capture;
        tmo    <= capture ? 1'b0 : (to_evt ? 1'b1 : tmo);
        rng    <= capture ? inch_nxt : rng;
        presc  <= (state == HIGH) ? (wrap ? '0 : presc + 1'b1) : '0;
        inch   <= (state == HIGH) ? inch_nxt : '0;
        to_cnt <= ((state == ARMED || state == HIGH) && state_nxt == state && !to_hit) ? to_cnt + 1'b1 : '0;
        tg_cnt <= (state == IDLE && state_nxt == TRIG) ? TG_W'(TRIG_CYCLES - 1) :
                  (tg_cnt != '0) ? tg_cnt - 1'b1 : tg_cnt;
      end
    assign gpio_tri_o[4*n +: 4]          = {3'b000, rx};
    assign gpio_tri_t[4*n +: 4]          = {3'b111, ~out_en};
    assign range_o[n*RANGE_W +: RANGE_W] = rng;
    assign range_valid_o[n]              = valid;
    assign timeout_o[n]                  = tmo;
    assign busy_o[n]                     = busy;
  end
endmodule
